lab2_proc_mem_arb: RTL and testbench

Two-to-one memory port arbiter that shares a single 4B memory request/response port between the processor's instruction and data memory streams. Requests from the imem and dmem request streams are granted onto one memory request stream. Because the memory returns responses in order, a route FIFO records which requester owns each outstanding request, and each response is steered back to that owner. The block sits between the processor's imem/dmem ports and a single-ported test memory or cache.

---
 rtl/lab2_proc_mem_arb_pkg.sv | 57 +++++
 rtl/lab2_proc_mem_arb_route_fifo.sv | 61 ++++++
 rtl/lab2_proc_mem_arb.sv | 121 ++++++++++++
 tb/tb_lab2_proc_mem_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_mem_arb_pkg.sv
// Shared types for the processor memory arbiter.
//   arb_id_t      : 1-bit requester ID stored in the route FIFO
//   ARB_ID_IMEM/ARB_ID_DMEM : requester encodings (0 / 1)
//   mem_req_4B_t  : 77-bit memory request  {typ, opaque, addr, len, data}
//   mem_resp_4B_t : 47-bit memory response {typ, opaque, test, len, data}
package lab2_proc_mem_arb_pkg;

  typedef logic [0:0] arb_id_t;

  localparam arb_id_t ARB_ID_IMEM = 1'b0;
  localparam arb_id_t ARB_ID_DMEM = 1'b1;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic mem_req_4B_t mk_mem_req(input logic [2:0]  i_typ,
                                             input logic [7:0]  i_opaque,
                                             input logic [31:0] i_addr,
                                             input logic [31:0] i_data);
    mem_req_4B_t m;
    m.typ    = i_typ;
    m.opaque = i_opaque;
    m.addr   = i_addr;
    m.len    = 2'd0;
    m.data   = i_data;
    return m;
  endfunction

  function automatic mem_resp_4B_t mk_mem_resp(input logic [2:0]  i_typ,
                                               input logic [7:0]  i_opaque,
                                               input logic [31:0] i_data);
    mem_resp_4B_t m;
    m.typ    = i_typ;
    m.opaque = i_opaque;
    m.test   = 2'd0;
    m.len    = 2'd0;
    m.data   = i_data;
    return m;
  endfunction

endpackage

// File: rtl/lab2_proc_mem_arb_route_fifo.sv
// Route FIFO: records which requester owns each in-flight memory request.
// Circular buffer of arb_id_t entries with head/tail pointers and a count.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : enqueue i_push_id (caller guarantees !o_full)
//   i_pop      : dequeue head (caller guarantees !o_empty)
//   o_full     : count == p_depth
//   o_empty    : count == 0
//   o_head     : ID at the head
//   o_count    : current occupancy
module lab2_proc_mem_arb_route_fifo
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter  int unsigned p_depth = 2,
  localparam int unsigned PTR_W   = (p_depth > 1) ? $clog2(p_depth) : 1,
  localparam int unsigned CNT_W   = $clog2(p_depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  arb_id_t          i_push_id,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output arb_id_t          o_head,
  output logic [CNT_W-1:0] o_count
);

  arb_id_t          r_mem [p_depth];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Wrap at depth so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < p_depth; i++) r_mem[i] <= ARB_ID_IMEM;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_id;
        r_tail        <= ptr_next(r_tail);
      end
      if (i_pop) r_head <= ptr_next(r_head);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_full  = (r_count == CNT_W'(p_depth));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/lab2_proc_mem_arb.sv
// Two-to-one memory port arbiter: shares one 4B memory port between the
// imem and dmem streams. Requests pass through combinationally; a route
// FIFO of requester IDs steers the in-order responses back to their owner.
// Configuration macro:
//   LAB2_PROC_MEM_ARB_RR_EN defined   : round-robin grant (1-bit priority reg)
//   LAB2_PROC_MEM_ARB_RR_EN undefined : fixed priority, dmem over imem
// Ports:
//   clk, reset                       : clock, async active-high reset
//   imem_reqstream_{msg,val,rdy}     : instruction request in
//   imem_respstream_{msg,val,rdy}    : instruction response out
//   dmem_reqstream_{msg,val,rdy}     : data request in
//   dmem_respstream_{msg,val,rdy}    : data response out
//   mem_reqstream_{msg,val,rdy}      : shared memory request out
//   mem_respstream_{msg,val,rdy}     : shared memory response in
//   num_outstanding                  : requests in flight (route FIFO count)
module lab2_proc_mem_arb
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter  int unsigned p_max_outstanding = 2,
  localparam int unsigned CNT_W = $clog2(p_max_outstanding + 1)
) (
  input  logic             clk,
  input  logic             reset,

  input  mem_req_4B_t      imem_reqstream_msg,
  input  logic             imem_reqstream_val,
  output logic             imem_reqstream_rdy,
  output mem_resp_4B_t     imem_respstream_msg,
  output logic             imem_respstream_val,
  input  logic             imem_respstream_rdy,

  input  mem_req_4B_t      dmem_reqstream_msg,
  input  logic             dmem_reqstream_val,
  output logic             dmem_reqstream_rdy,
  output mem_resp_4B_t     dmem_respstream_msg,
  output logic             dmem_respstream_val,
  input  logic             dmem_respstream_rdy,

  output mem_req_4B_t      mem_reqstream_msg,
  output logic             mem_reqstream_val,
  input  logic             mem_reqstream_rdy,
  input  mem_resp_4B_t     mem_respstream_msg,
  input  logic             mem_respstream_val,
  output logic             mem_respstream_rdy,

  output logic [CNT_W-1:0] num_outstanding
);

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_req_rdy;
  logic    w_resp_ok;
  arb_id_t w_grant;
  arb_id_t w_head;

`ifdef LAB2_PROC_MEM_ARB_RR_EN
  arb_id_t r_prio;

  // Priority only matters when both are valid; a lone requester always wins.
  always_comb begin
    w_grant = r_prio;
    if (imem_reqstream_val && !dmem_reqstream_val)      w_grant = ARB_ID_IMEM;
    else if (dmem_reqstream_val && !imem_reqstream_val) w_grant = ARB_ID_DMEM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_prio <= ARB_ID_DMEM;
    else if (w_push) r_prio <= ~w_grant;
  end
`else
  always_comb begin
    w_grant = dmem_reqstream_val ? ARB_ID_DMEM : ARB_ID_IMEM;
  end
`endif

  // Request side. A full FIFO blocks the push even if a pop happens in the
  // same cycle, so no combinational path runs from response to request.
  assign mem_reqstream_msg  = (w_grant == ARB_ID_DMEM) ? dmem_reqstream_msg
                                                       : imem_reqstream_msg;
  assign mem_reqstream_val  = !reset && (imem_reqstream_val || dmem_reqstream_val)
                              && !w_full;
  assign w_req_rdy          = !reset && mem_reqstream_rdy && !w_full;
  assign imem_reqstream_rdy = w_req_rdy && (w_grant == ARB_ID_IMEM);
  assign dmem_reqstream_rdy = w_req_rdy && (w_grant == ARB_ID_DMEM);
  assign w_push             = mem_reqstream_val && mem_reqstream_rdy;

  // Response side: only val/rdy are steered, msg is broadcast.
  assign w_resp_ok           = !reset && !w_empty;
  assign imem_respstream_msg = mem_respstream_msg;
  assign dmem_respstream_msg = mem_respstream_msg;
  assign imem_respstream_val = w_resp_ok && mem_respstream_val && (w_head == ARB_ID_IMEM);
  assign dmem_respstream_val = w_resp_ok && mem_respstream_val && (w_head == ARB_ID_DMEM);
  assign mem_respstream_rdy  = w_resp_ok && ((w_head == ARB_ID_DMEM) ? dmem_respstream_rdy
                                                                     : imem_respstream_rdy);
  assign w_pop               = mem_respstream_val && mem_respstream_rdy;

  lab2_proc_mem_arb_route_fifo #(
    .p_depth (p_max_outstanding)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (reset),
    .i_push    (w_push),
    .i_push_id (w_grant),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head),
    .o_count   (num_outstanding)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory side is out of step.
  always @(posedge clk) begin
    if (!reset && mem_respstream_val && w_empty)
      $error("lab2_proc_mem_arb: memory response with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arb.sv
module tb_lab2_proc_mem_arb;
  import lab2_proc_mem_arb_pkg::*;

  localparam int unsigned P  = 2;
  localparam int unsigned CW = $clog2(P + 1);
`ifdef LAB2_PROC_MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic         clk;
  logic         reset;
  mem_req_4B_t  imem_reqstream_msg;
  logic         imem_reqstream_val;
  logic         imem_reqstream_rdy;
  mem_resp_4B_t imem_respstream_msg;
  logic         imem_respstream_val;
  logic         imem_respstream_rdy;
  mem_req_4B_t  dmem_reqstream_msg;
  logic         dmem_reqstream_val;
  logic         dmem_reqstream_rdy;
  mem_resp_4B_t dmem_respstream_msg;
  logic         dmem_respstream_val;
  logic         dmem_respstream_rdy;
  mem_req_4B_t  mem_reqstream_msg;
  logic         mem_reqstream_val;
  logic         mem_reqstream_rdy;
  mem_resp_4B_t mem_respstream_msg;
  logic         mem_respstream_val;
  logic         mem_respstream_rdy;
  logic [CW-1:0] num_outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  lab2_proc_mem_arb #(.p_max_outstanding(P)) dut (
    .clk                 (clk),
    .reset               (reset),
    .imem_reqstream_msg  (imem_reqstream_msg),
    .imem_reqstream_val  (imem_reqstream_val),
    .imem_reqstream_rdy  (imem_reqstream_rdy),
    .imem_respstream_msg (imem_respstream_msg),
    .imem_respstream_val (imem_respstream_val),
    .imem_respstream_rdy (imem_respstream_rdy),
    .dmem_reqstream_msg  (dmem_reqstream_msg),
    .dmem_reqstream_val  (dmem_reqstream_val),
    .dmem_reqstream_rdy  (dmem_reqstream_rdy),
    .dmem_respstream_msg (dmem_respstream_msg),
    .dmem_respstream_val (dmem_respstream_val),
    .dmem_respstream_rdy (dmem_respstream_rdy),
    .mem_reqstream_msg   (mem_reqstream_msg),
    .mem_reqstream_val   (mem_reqstream_val),
    .mem_reqstream_rdy   (mem_reqstream_rdy),
    .mem_respstream_msg  (mem_respstream_msg),
    .mem_respstream_val  (mem_respstream_val),
    .mem_respstream_rdy  (mem_respstream_rdy),
    .num_outstanding     (num_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_reqstream_val  = 1'b0;
    dmem_reqstream_val  = 1'b0;
    mem_respstream_val  = 1'b0;
    mem_reqstream_rdy   = 1'b1;
    imem_respstream_rdy = 1'b1;
    dmem_respstream_rdy = 1'b1;
    imem_reqstream_msg  = '0;
    dmem_reqstream_msg  = '0;
    mem_respstream_msg  = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    imem_reqstream_val = 1'b1;
    dmem_reqstream_val = 1'b1;
    mem_respstream_val = 1'b1;
    #3;
    n_cmp++; if (mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req_val got %b exp 0", mem_reqstream_val); end
    n_cmp++; if (imem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_imem_rdy got %b exp 0", imem_reqstream_rdy); end
    n_cmp++; if (dmem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_dmem_rdy got %b exp 0", dmem_reqstream_rdy); end
    n_cmp++; if (mem_respstream_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_mem_resp_rdy got %b exp 0", mem_respstream_rdy); end
    n_cmp++; if (imem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL rst_imem_resp_val got %b exp 0", imem_respstream_val); end
    n_cmp++; if (dmem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL rst_dmem_resp_val got %b exp 0", dmem_respstream_val); end
    step();
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", num_outstanding); end
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_imem_only();
    mem_req_4B_t  req_a, req_b;
    mem_resp_4B_t resp_a, resp_b;
    req_a  = mk_mem_req(MEM_TYPE_READ, 8'h01, 32'h0000_0200, 32'h0);
    req_b  = mk_mem_req(MEM_TYPE_READ, 8'h02, 32'h0000_0204, 32'h0);
    resp_a = mk_mem_resp(MEM_TYPE_READ, 8'h01, 32'hCAFE_0200);
    resp_b = mk_mem_resp(MEM_TYPE_READ, 8'h02, 32'hCAFE_0204);
    do_reset();
    imem_reqstream_val = 1'b1;
    imem_reqstream_msg = req_a;
    #1;
    n_cmp++; if (mem_reqstream_val !== 1'b1) begin n_bad++; $display("FAIL imem_req_val got %b exp 1", mem_reqstream_val); end
    n_cmp++; if (mem_reqstream_msg !== req_a) begin n_bad++; $display("FAIL imem_req_msg_a got %h exp %h", mem_reqstream_msg, req_a); end
    n_cmp++; if (imem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL imem_rdy got %b exp 1", imem_reqstream_rdy); end
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL imem_cnt0 got %0d exp 0", num_outstanding); end
    step();
    imem_reqstream_msg = req_b;
    #1;
    n_cmp++; if (mem_reqstream_msg !== req_b) begin n_bad++; $display("FAIL imem_req_msg_b got %h exp %h", mem_reqstream_msg, req_b); end
    n_cmp++; if (num_outstanding !== 2'd1) begin n_bad++; $display("FAIL imem_cnt1 got %0d exp 1", num_outstanding); end
    step();
    imem_reqstream_val = 1'b0;
    mem_respstream_val = 1'b1;
    mem_respstream_msg = resp_a;
    #1;
    n_cmp++; if (num_outstanding !== 2'd2) begin n_bad++; $display("FAIL imem_cnt2 got %0d exp 2", num_outstanding); end
    n_cmp++; if (imem_respstream_val !== 1'b1) begin n_bad++; $display("FAIL imem_resp_val_a got %b exp 1", imem_respstream_val); end
    n_cmp++; if (imem_respstream_msg !== resp_a) begin n_bad++; $display("FAIL imem_resp_msg_a got %h exp %h", imem_respstream_msg, resp_a); end
    n_cmp++; if (dmem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL imem_dresp_val_a got %b exp 0", dmem_respstream_val); end
    n_cmp++; if (mem_respstream_rdy !== 1'b1) begin n_bad++; $display("FAIL imem_mem_resp_rdy got %b exp 1", mem_respstream_rdy); end
    step();
    mem_respstream_msg = resp_b;
    #1;
    n_cmp++; if (num_outstanding !== 2'd1) begin n_bad++; $display("FAIL imem_cnt3 got %0d exp 1", num_outstanding); end
    n_cmp++; if (imem_respstream_val !== 1'b1) begin n_bad++; $display("FAIL imem_resp_val_b got %b exp 1", imem_respstream_val); end
    n_cmp++; if (imem_respstream_msg !== resp_b) begin n_bad++; $display("FAIL imem_resp_msg_b got %h exp %h", imem_respstream_msg, resp_b); end
    n_cmp++; if (dmem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL imem_dresp_val_b got %b exp 0", dmem_respstream_val); end
    step();
    mem_respstream_val = 1'b0;
    #1;
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL imem_cnt4 got %0d exp 0", num_outstanding); end
  endtask

  // Both requesters valid every cycle; memory answers each request one cycle later.
  task automatic test_simultaneous();
    arb_id_t     exp_g [4];
    mem_req_4B_t ireq, dreq, exp_msg;
    for (int k = 0; k < 4; k++)
      exp_g[k] = (RR_MODE && (k % 2 == 1)) ? ARB_ID_IMEM : ARB_ID_DMEM;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      ireq = mk_mem_req(MEM_TYPE_READ,  8'(8'h10 + k), 32'h0000_1000 + 32'(4 * k), 32'h0);
      dreq = mk_mem_req(MEM_TYPE_WRITE, 8'(8'h20 + k), 32'h0000_2000 + 32'(4 * k), 32'(k));
      imem_reqstream_val = (k < 4);
      dmem_reqstream_val = (k < 4);
      imem_reqstream_msg = ireq;
      dmem_reqstream_msg = dreq;
      mem_respstream_val = (k > 0);
      mem_respstream_msg = mk_mem_resp(MEM_TYPE_READ, 8'(k), 32'(k));
      #1;
      if (k < 4) begin
        exp_msg = (exp_g[k] == ARB_ID_DMEM) ? dreq : ireq;
        n_cmp++; if (mem_reqstream_msg !== exp_msg) begin n_bad++; $display("FAIL sim_grant_msg[%0d] got %h exp %h", k, mem_reqstream_msg, exp_msg); end
        n_cmp++; if (dmem_reqstream_rdy !== (exp_g[k] == ARB_ID_DMEM)) begin n_bad++; $display("FAIL sim_dmem_rdy[%0d] got %b exp %b", k, dmem_reqstream_rdy, exp_g[k] == ARB_ID_DMEM); end
        n_cmp++; if (imem_reqstream_rdy !== (exp_g[k] == ARB_ID_IMEM)) begin n_bad++; $display("FAIL sim_imem_rdy[%0d] got %b exp %b", k, imem_reqstream_rdy, exp_g[k] == ARB_ID_IMEM); end
      end
      if (k > 0) begin
        n_cmp++; if (dmem_respstream_val !== (exp_g[k-1] == ARB_ID_DMEM)) begin n_bad++; $display("FAIL sim_dresp_val[%0d] got %b exp %b", k - 1, dmem_respstream_val, exp_g[k-1] == ARB_ID_DMEM); end
        n_cmp++; if (imem_respstream_val !== (exp_g[k-1] == ARB_ID_IMEM)) begin n_bad++; $display("FAIL sim_iresp_val[%0d] got %b exp %b", k - 1, imem_respstream_val, exp_g[k-1] == ARB_ID_IMEM); end
      end
      n_cmp++; if (num_outstanding !== ((k == 0) ? 2'd0 : 2'd1)) begin n_bad++; $display("FAIL sim_cnt[%0d] got %0d exp %0d", k, num_outstanding, (k == 0) ? 0 : 1); end
      step();
    end
    idle();
    #1;
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL sim_cnt_end got %0d exp 0", num_outstanding); end
  endtask

  task automatic test_full();
    arb_id_t g4;
    g4 = RR_MODE ? ARB_ID_IMEM : ARB_ID_DMEM;
    do_reset();
    dmem_reqstream_val = 1'b1;
    dmem_reqstream_msg = mk_mem_req(MEM_TYPE_READ, 8'h30, 32'h0000_3000, 32'h0);
    #1;
    n_cmp++; if (dmem_reqstream_rdy !== 1'b1) begin n_bad++; $display("FAIL full_rdy0 got %b exp 1", dmem_reqstream_rdy); end
    step();
    n_cmp++; if (num_outstanding !== 2'd1) begin n_bad++; $display("FAIL full_cnt1 got %0d exp 1", num_outstanding); end
    step();
    imem_reqstream_val = 1'b1;
    #1;
    n_cmp++; if (num_outstanding !== 2'd2) begin n_bad++; $display("FAIL full_cnt2 got %0d exp 2", num_outstanding); end
    n_cmp++; if (mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL full_req_val got %b exp 0", mem_reqstream_val); end
    n_cmp++; if (imem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL full_imem_rdy got %b exp 0", imem_reqstream_rdy); end
    n_cmp++; if (dmem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL full_dmem_rdy got %b exp 0", dmem_reqstream_rdy); end
    step();
    mem_respstream_val = 1'b1;
    mem_respstream_msg = mk_mem_resp(MEM_TYPE_READ, 8'h30, 32'h3);
    #1;
    n_cmp++; if (mem_respstream_rdy !== 1'b1) begin n_bad++; $display("FAIL full_pop_rdy got %b exp 1", mem_respstream_rdy); end
    n_cmp++; if (dmem_respstream_val !== 1'b1) begin n_bad++; $display("FAIL full_pop_dval got %b exp 1", dmem_respstream_val); end
    n_cmp++; if (mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL full_pop_req_val got %b exp 0", mem_reqstream_val); end
    n_cmp++; if (dmem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL full_pop_dmem_rdy got %b exp 0", dmem_reqstream_rdy); end
    step();
    mem_respstream_val = 1'b0;
    #1;
    n_cmp++; if (num_outstanding !== 2'd1) begin n_bad++; $display("FAIL full_cnt_after_pop got %0d exp 1", num_outstanding); end
    n_cmp++; if (mem_reqstream_val !== 1'b1) begin n_bad++; $display("FAIL full_retry_val got %b exp 1", mem_reqstream_val); end
    n_cmp++; if (imem_reqstream_rdy !== (g4 == ARB_ID_IMEM)) begin n_bad++; $display("FAIL full_retry_imem_rdy got %b exp %b", imem_reqstream_rdy, g4 == ARB_ID_IMEM); end
    n_cmp++; if (dmem_reqstream_rdy !== (g4 == ARB_ID_DMEM)) begin n_bad++; $display("FAIL full_retry_dmem_rdy got %b exp %b", dmem_reqstream_rdy, g4 == ARB_ID_DMEM); end
    step();
    imem_reqstream_val = 1'b0;
    dmem_reqstream_val = 1'b0;
    mem_respstream_val = 1'b1;
    #1;
    n_cmp++; if (num_outstanding !== 2'd2) begin n_bad++; $display("FAIL full_cnt_refill got %0d exp 2", num_outstanding); end
    step();
    step();
    mem_respstream_val = 1'b0;
    #1;
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL full_cnt_drain got %0d exp 0", num_outstanding); end
  endtask

  task automatic test_backpressure();
    do_reset();
    dmem_reqstream_val = 1'b1;
    dmem_reqstream_msg = mk_mem_req(MEM_TYPE_READ, 8'h40, 32'h0000_4000, 32'h0);
    step();
    dmem_reqstream_val  = 1'b0;
    dmem_respstream_rdy = 1'b0;
    imem_respstream_rdy = 1'b1;
    mem_respstream_val  = 1'b1;
    mem_respstream_msg  = mk_mem_resp(MEM_TYPE_READ, 8'h40, 32'h4);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (mem_respstream_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_mem_rdy[%0d] got %b exp 0", i, mem_respstream_rdy); end
      n_cmp++; if (dmem_respstream_val !== 1'b1) begin n_bad++; $display("FAIL bp_dval[%0d] got %b exp 1", i, dmem_respstream_val); end
      n_cmp++; if (imem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL bp_ival[%0d] got %b exp 0", i, imem_respstream_val); end
      n_cmp++; if (num_outstanding !== 2'd1) begin n_bad++; $display("FAIL bp_cnt[%0d] got %0d exp 1", i, num_outstanding); end
      step();
    end
    dmem_respstream_rdy = 1'b1;
    #1;
    n_cmp++; if (mem_respstream_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_release_rdy got %b exp 1", mem_respstream_rdy); end
    n_cmp++; if (imem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL bp_release_ival got %b exp 0", imem_respstream_val); end
    step();
    mem_respstream_val = 1'b0;
    #1;
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL bp_cnt_end got %0d exp 0", num_outstanding); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    imem_reqstream_val = 1'b1;
    imem_reqstream_msg = mk_mem_req(MEM_TYPE_READ, 8'h50, 32'h0000_5000, 32'h0);
    step();
    step();
    n_cmp++; if (num_outstanding !== 2'd2) begin n_bad++; $display("FAIL mid_cnt_pre got %0d exp 2", num_outstanding); end
    dmem_reqstream_val = 1'b1;
    mem_respstream_val = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL mid_cnt got %0d exp 0", num_outstanding); end
    n_cmp++; if (mem_reqstream_val !== 1'b0) begin n_bad++; $display("FAIL mid_req_val got %b exp 0", mem_reqstream_val); end
    n_cmp++; if (imem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_imem_rdy got %b exp 0", imem_reqstream_rdy); end
    n_cmp++; if (dmem_reqstream_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_dmem_rdy got %b exp 0", dmem_reqstream_rdy); end
    n_cmp++; if (mem_respstream_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_resp_rdy got %b exp 0", mem_respstream_rdy); end
    n_cmp++; if (imem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL mid_ival got %b exp 0", imem_respstream_val); end
    n_cmp++; if (dmem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL mid_dval got %b exp 0", dmem_respstream_val); end
    step();
    imem_reqstream_val = 1'b0;
    dmem_reqstream_val = 1'b0;
    reset = 1'b0;
    // Stray response is presented only between edges.
    #1;
    n_cmp++; if (mem_respstream_rdy !== 1'b0) begin n_bad++; $display("FAIL stray_rdy got %b exp 0", mem_respstream_rdy); end
    n_cmp++; if (imem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL stray_ival got %b exp 0", imem_respstream_val); end
    n_cmp++; if (dmem_respstream_val !== 1'b0) begin n_bad++; $display("FAIL stray_dval got %b exp 0", dmem_respstream_val); end
    mem_respstream_val = 1'b0;
    step();
    n_cmp++; if (num_outstanding !== 2'd0) begin n_bad++; $display("FAIL stray_cnt got %0d exp 0", num_outstanding); end
  endtask

  initial begin
    test_reset();
    test_imem_only();
    test_simultaneous();
    test_full();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
